fp_int_mac_vec: RTL
===================

Name: fp_int_mac_vec

Overview:
- Multi-lane successor to the single-lane bit-serial fp16 x intN MAC.
- LANES fp16 activations are each multiplied by a signed weight of runtime precision P. Weights are serialised internally, MSB first, one bit per cycle.
- Lane products are aligned to a per-tile block exponent, summed, and accumulated into a saturating fixed-point register.
- Sits in a systolic/array column. It has a valid/ready vector input and a valid/ready result output, replacing free-running done pulses.

Parameters:
- LANES, 4, number of parallel activation/weight lanes (power of 2, >=1).
- ACT_WIDTH, 16, activation width (fp16: 1 sign, 5 exponent, 10 mantissa).
- MAX_PREC, 8, maximum weight precision and per-lane weight field width.
- ACC_WIDTH, 32, signed accumulator width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  vector offered.
- in_ready  out  1  vector accepted when in_valid&in_ready.
- act  in  LANES*ACT_WIDTH  lane l at [l*16 +: 16].
- w  in  LANES*MAX_PREC  lane l weight in low P bits of its field, two's complement.
- precision  in  4  weight precision P for this vector.
- first  in  1  vector opens a tile: load accumulator and exponent.
- last  in  1  vector closes tile: emit result.
- exp_set  in  5  block exponent E, sampled when first=1.
- acc_init  in  ACC_WIDTH  accumulator initial value, sampled when first=1 (cascade input).
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid&out_ready.
- acc_out  out  ACC_WIDTH  signed result.
- exp_out  out  5  result exponent. Value = acc_out * 2^(exp_out-25).
- flags  out  2  [0]=ovf (any saturation in tile), [1]=nan (inf/NaN seen in tile). Sticky per tile.

Behaviour:
- Reset, synchronous: state IDLE, in_ready=1, out_valid=0, acc_out=0, exp_out=15, flags=0, internal acc=0, E=15.
- Reset mid-operation aborts the vector or tile; no partial result is emitted.
- P clamping: P<2 is treated as 2; P>MAX_PREC is treated as MAX_PREC. Bits of w above P are ignored.
- Lane decode, per lane:
  - e==0: term 0 (denormal flush).
  - e==31: term 0, set nan.
  - Otherwise sig = {1, m} (11 bits) and s = sign.
- Lane product: signed PW = 12+MAX_PREC bits, p = (s ? -1 : 1) * sig * W.
  - Computed bit-serially MSB first: the first bit weighs -sig, then p <= 2p + bit*sig.
  - Sign is applied after the last bit.
- Alignment, per lane:
  - e<=E: term = p >>> (E-e), arithmetic shift. Shift >= PW gives sign fill.
  - e>E: term clamps to +/-(2^(PW-1)-1) by sign of p, and ovf is set.
- Lane sum: width PW+log2(LANES), exact. Sign-extend to ACC_WIDTH.
- Accumulate: acc <= sat(acc + sum), saturating to signed ACC_WIDTH max/min. Set ovf on saturation.
- first=1 on accept: acc <= acc_init, E <= exp_set, flags cleared, before this vector's sum is added.
- first=1 without a preceding last discards the open tile.
- FSM states:
  - IDLE: in_ready=1. On accept, latch act, w, P, first, last (and E/acc_init if first) -> MUL, cnt=0.
  - MUL: one weight bit per edge; after P edges -> SUM.
  - SUM: one edge; latch the aligned lane sum -> ACC.
  - ACC: one edge; update acc. If last: load acc_out, exp_out=E, flags; set out_valid -> OUT. Otherwise -> IDLE.
  - OUT: hold out_valid and outputs stable until out_ready -> IDLE (out_valid=0).
- Timing:
  - in_ready=0 outside IDLE.
  - Accept at edge E0; out_valid rises after edge E0+P+2.
  - Earliest next accept is at E0+P+3.
- acc_out, exp_out and flags keep their last values after handshake. They change only on the next result or on rst.

Test Plan:
- LANES=4, P=4, first=last=1, E=15, act all 0x3C00, w=1,2,3,-1 (0xF) -> acc_out=5120, exp_out=15, flags=0. out_valid 6 cycles after accept.
- E=16, act lane0=0x4000 w=1, lane1=0x3C00 w=1, others 0 -> acc_out=1536 (1024 + 1024>>1).
- act lane0=0xBE00 (-1.5), P=4, w=0x8 (-8), acc_init=0 -> acc_out=12288. Then acc_init=-100 with the same vector -> 12188.
- Three vectors (first, middle, last) each summing to 5120 -> a single out_valid, acc_out=15360. Hold out_ready=0 for 5 cycles: out_valid and data stable, in_ready=0. Release -> IDLE.
- ACC_WIDTH=20, P=8, E=30, all lanes 0x7BFF with w=127 -> acc_out=524287, flags[0]=1. Also lane e>E -> ovf; 0x7C00 -> flags[1]=1 with term 0; 0x0001 -> term 0.
- rst pulsed for 1 cycle during MUL -> next cycle in_ready=1, out_valid=0, acc_out=0. The following tile computes correctly from acc_init.

Source files
------------

// File: rtl/fp_int_mac_vec_if.sv
// Vector-in / result-out handshake bundle for the multi-lane fp16 x intN MAC.
// The master side offers vectors and consumes results; the slave side is the MAC.
interface fp_int_mac_vec_if #(
  parameter int LANES     = 4,
  parameter int ACT_WIDTH = 16,
  parameter int MAX_PREC  = 8,
  parameter int ACC_WIDTH = 32
);
  logic                          in_valid;
  logic                          in_ready;
  logic [LANES*ACT_WIDTH-1:0]    act;
  logic [LANES*MAX_PREC-1:0]     w;
  logic [3:0]                    precision;
  logic                          first;
  logic                          last;
  logic [4:0]                    exp_set;
  logic signed [ACC_WIDTH-1:0]   acc_init;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [ACC_WIDTH-1:0]   acc_out;
  logic [4:0]                    exp_out;
  logic [1:0]                    flags;

  modport master (
    output in_valid, act, w, precision, first, last, exp_set, acc_init, out_ready,
    input  in_ready, out_valid, acc_out, exp_out, flags
  );

  modport slave (
    input  in_valid, act, w, precision, first, last, exp_set, acc_init, out_ready,
    output in_ready, out_valid, acc_out, exp_out, flags
  );
endinterface

// File: rtl/fp_int_mac_vec.sv
// Multi-lane fp16 x signed-intN MAC: bit-serial weights (MSB first), block-exponent
// alignment of lane products, and a saturating per-tile accumulator with valid/ready I/O.
module fp_int_mac_vec #(
  parameter int LANES     = 4,
  parameter int ACT_WIDTH = 16,
  parameter int MAX_PREC  = 8,
  parameter int ACC_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  fp_int_mac_vec_if.slave   bus
);
  localparam int PW  = 12 + MAX_PREC;
  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int SW  = PW + LW;
  localparam int XW  = ((ACC_WIDTH > SW) ? ACC_WIDTH : SW) + 1;
  localparam int PRW = $clog2(MAX_PREC + 1);

  localparam logic signed [SW-1:0]        TERM_MAX  = SW'((64'sd1 <<< (PW - 1)) - 64'sd1);
  localparam logic signed [PW-1:0]        ZERO_P    = '0;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [XW-1:0]        ACC_MAX_X = XW'(ACC_MAX);
  localparam logic signed [XW-1:0]        ACC_MIN_X = XW'(ACC_MIN);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_SUM, S_ACC, S_OUT} state_e;

  function automatic logic [PRW-1:0] clamp_prec(input logic [3:0] p);
    if (int'(p) < 2)        return PRW'(2);
    if (int'(p) > MAX_PREC) return PRW'(MAX_PREC);
    return PRW'(p);
  endfunction

  // Lanes whose exponent exceeds the block exponent cannot be represented and clamp.
  function automatic logic signed [SW-1:0] align_term(input logic [4:0] e,
                                                      input logic [4:0] eb,
                                                      input logic signed [PW-1:0] p);
    logic signed [SW-1:0] pw;
    pw = SW'(p);
    if (e == 5'd0 || e == 5'd31) return '0;
    if (e > eb) return (p < 0) ? -TERM_MAX : TERM_MAX;
    return pw >>> (eb - e);
  endfunction

  function automatic logic sat_hit(input logic signed [XW-1:0] v);
    return (v > ACC_MAX_X) || (v < ACC_MIN_X);
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [XW-1:0] v);
    if (v > ACC_MAX_X) return ACC_MAX;
    if (v < ACC_MIN_X) return ACC_MIN;
    return v[ACC_WIDTH-1:0];
  endfunction

  state_e                       state_q, state_d;
  logic [PRW-1:0]               cnt_q;
  logic [PRW-1:0]               p_q;
  logic [PRW-1:0]               prec_c;
  logic                         accept;
  logic                         last_q;
  logic [LANES*ACT_WIDTH-1:0]   act_q;
  logic [MAX_PREC-1:0]          w_q    [LANES];
  logic signed [PW-1:0]         prod_q [LANES];
  logic signed [PW-1:0]         prod_d [LANES];
  logic signed [PW-1:0]         sig;
  logic signed [PW-1:0]         pp;
  logic                         wbit;
  logic [4:0]                   ex;
  logic signed [SW-1:0]         lane_sum;
  logic                         lane_ovf;
  logic                         lane_nan;
  logic signed [SW-1:0]         sum_q;
  logic [1:0]                   sflg_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic [4:0]                   exp_q;
  logic [1:0]                   flg_q;
  logic signed [XW-1:0]         acc_x;
  logic                         acc_hit;
  logic signed [ACC_WIDTH-1:0]  acc_new;
  logic [1:0]                   flg_new;
  logic signed [ACC_WIDTH-1:0]  acc_out_q;
  logic [4:0]                   exp_out_q;
  logic [1:0]                   flags_q;

  assign accept        = (state_q == S_IDLE) && bus.in_valid;
  assign prec_c        = clamp_prec(bus.precision);
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.acc_out   = acc_out_q;
  assign bus.exp_out   = exp_out_q;
  assign bus.flags     = flags_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_MUL;
      S_MUL:   if (cnt_q == p_q - PRW'(1)) state_d = S_SUM;
      S_SUM:   state_d = S_ACC;
      S_ACC:   state_d = last_q ? S_OUT : S_IDLE;
      S_OUT:   if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // MUL stage: first weight bit is the two's-complement sign bit, sign of the
  // activation folds in on the final bit.
  always_comb begin
    sig  = '0;
    wbit = 1'b0;
    pp   = '0;
    for (int l = 0; l < LANES; l++) begin
      sig  = {{(PW-11){1'b0}}, 1'b1, act_q[l*ACT_WIDTH +: 10]};
      wbit = w_q[l][MAX_PREC-1];
      if (cnt_q == '0) pp = wbit ? -sig : ZERO_P;
      else             pp = (prod_q[l] <<< 1) + (wbit ? sig : ZERO_P);
      if ((cnt_q == p_q - PRW'(1)) && act_q[l*ACT_WIDTH + 15]) pp = -pp;
      prod_d[l] = pp;
    end
  end

  // SUM stage: align every lane to the block exponent and add exactly.
  always_comb begin
    lane_sum = '0;
    lane_ovf = 1'b0;
    lane_nan = 1'b0;
    ex       = '0;
    for (int l = 0; l < LANES; l++) begin
      ex       = act_q[l*ACT_WIDTH + 10 +: 5];
      lane_sum = lane_sum + align_term(ex, exp_q, prod_q[l]);
      if (ex == 5'd31)                    lane_nan = 1'b1;
      else if (ex != 5'd0 && ex > exp_q)  lane_ovf = 1'b1;
    end
  end

  // ACC stage: saturating accumulate in a width that cannot wrap.
  always_comb begin
    acc_x   = XW'(acc_q) + XW'(sum_q);
    acc_hit = sat_hit(acc_x);
    acc_new = sat_acc(acc_x);
    flg_new = flg_q | sflg_q | {1'b0, acc_hit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      exp_q     <= 5'd15;
      flg_q     <= '0;
      acc_out_q <= '0;
      exp_out_q <= 5'd15;
      flags_q   <= '0;
    end else begin
      if (accept) begin
        cnt_q <= '0;
        if (bus.first) begin
          acc_q <= bus.acc_init;
          exp_q <= bus.exp_set;
          flg_q <= '0;
        end
      end
      if (state_q == S_MUL) cnt_q <= cnt_q + PRW'(1);
      if (state_q == S_ACC) begin
        acc_q <= acc_new;
        flg_q <= flg_new;
        if (last_q) begin
          acc_out_q <= acc_new;
          exp_out_q <= exp_q;
          flags_q   <= flg_new;
        end
      end
    end
  end

  // Weights are left-aligned so the P-bit field's sign bit is always the MSB.
  always_ff @(posedge clk) begin
    if (accept) begin
      act_q  <= bus.act;
      last_q <= bus.last;
      p_q    <= prec_c;
      for (int l = 0; l < LANES; l++)
        w_q[l] <= bus.w[l*MAX_PREC +: MAX_PREC] << (MAX_PREC - int'(prec_c));
    end
    if (state_q == S_MUL) begin
      for (int l = 0; l < LANES; l++) begin
        prod_q[l] <= prod_d[l];
        w_q[l]    <= w_q[l] << 1;
      end
    end
    if (state_q == S_SUM) begin
      sum_q  <= lane_sum;
      sflg_q <= {lane_nan, lane_ovf};
    end
  end
endmodule
